// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

    // ARB: pick a requester, RD: poll UART status, WR: write the byte,
    // GAP: one idle cycle between bus transactions.
    typedef enum logic [1:0] {
        ARB = 2'd0,
        RD  = 2'd1,
        WR  = 2'd2,
        GAP = 2'd3
    } state_t;

    // Status bit that reads 1 when the UART transmit buffer can take a byte.
    localparam int         STATUS_EMPTY_BIT = 0;
    localparam logic [3:0] WSTRB_READ       = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE0      = 4'b0001;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin winner search
//
// Purpose: starting at index ptr and wrapping modulo NUM_REQ, return the first
// set bit of req.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - index searched first
//   winner - index of the first request found (0 when none)
//   found  - high when any bit of req is set
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       found
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down to offset 0, so the nearest request
    // to ptr is the last to overwrite winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding a polled UART transmitter
//
// Purpose: grant one of NUM_REQ byte requesters, poll the UART status word
// until its transmit buffer is empty, write the byte, then acknowledge the
// requester with a one-cycle req_ready pulse.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   req_valid/req_data/req_last   - per-requester byte offer (data packed 8 bits each)
//   req_ready                     - one-cycle acknowledge of the written byte
//   grant_id                      - current or last granted requester
//   busy                          - high whenever the FSM is not in ARB
//   m_valid/m_instr/m_wstrb/m_wdata/m_addr/m_ready/m_rdata - bus master port
// Build option: UART_ARB_LOCK_EN keeps the grant on one requester until it
// delivers a byte with req_last set.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter logic [31:0] UART_ADDR = 32'hFFFF_0040
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       m_valid,
    output logic                       m_instr,
    output logic [3:0]                 m_wstrb,
    output logic [31:0]                m_wdata,
    output logic [31:0]                m_addr,
    input  logic                       m_ready,
    input  logic [31:0]                m_rdata
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic                 target_wr_q, target_wr_d;   // after GAP: 1 -> WR, 0 -> RD
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [7:0]           byte_q, byte_d;
    logic                 held_q, held_d;             // byte_q holds the sampled byte

    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic [7:0]           cur_byte;
    logic                 unused_bits;

    assign cur_byte = req_data[{grant_q, 3'b000} +: 8];

`ifdef UART_ARB_LOCK_EN
    logic                 lock_q, lock_d;
    logic [NUM_REQ-1:0]   grant_mask;

    always_comb begin
        grant_mask          = '0;
        grant_mask[grant_q] = 1'b1;
        eligible            = lock_q ? (req_valid & grant_mask) : req_valid;
    end

    assign unused_bits = ^m_rdata[31:1];
`else
    assign eligible    = req_valid;
    assign unused_bits = ^{m_rdata[31:1], req_last};
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (eligible),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d     = state_q;
        target_wr_d = target_wr_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        ready_d     = '0;
        byte_d      = byte_q;
        held_d      = held_q;
`ifdef UART_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        m_valid     = 1'b0;
        m_wstrb     = WSTRB_READ;
        m_addr      = '0;
        m_wdata     = '0;

        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d = winner;
                    ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                m_valid = 1'b1;
                m_addr  = UART_ADDR;
                if (m_ready) begin
                    target_wr_d = m_rdata[STATUS_EMPTY_BIT];
                    state_d     = GAP;
                end
            end
            WR: begin
                m_valid = 1'b1;
                m_wstrb = WSTRB_BYTE0;
                m_addr  = UART_ADDR;
                // Capture the byte on the first WR cycle so a requester that
                // misbehaves mid-write cannot change what is being written.
                m_wdata = {24'b0, held_q ? byte_q : cur_byte};
                if (!held_q) begin
                    byte_d = cur_byte;
                    held_d = 1'b1;
                end
                if (m_ready) begin
                    ready_d[grant_q] = 1'b1;
                    held_d           = 1'b0;
                    target_wr_d      = 1'b0;
`ifdef UART_ARB_LOCK_EN
                    lock_d           = ~req_last[grant_q];
`endif
                    state_d          = GAP;
                end
            end
            GAP: begin
                // A pending acknowledge marks the GAP that follows a write.
                if (|ready_q) begin
                    state_d = ARB;
                end else if (target_wr_q) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            target_wr_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
            ready_q     <= '0;
            byte_q      <= '0;
            held_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            target_wr_q <= target_wr_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            byte_q      <= byte_d;
            held_q      <= held_d;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ARB);
    assign m_instr   = 1'b0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for the UART transmit arbiter
module tb_uart_tx_arbiter;
    localparam int          N    = 4;
    localparam logic [31:0] ADDR = 32'hFFFF_0040;
    localparam int          IDLE_BUDGET = 3000;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             m_valid;
    logic             m_instr;
    logic [3:0]       m_wstrb;
    logic [31:0]      m_wdata;
    logic [31:0]      m_addr;
    logic             m_ready;
    logic [31:0]      m_rdata;

    uart_tx_arbiter #(.NUM_REQ(N), .UART_ADDR(ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_instr   (m_instr),
        .m_wstrb   (m_wstrb),
        .m_wdata   (m_wdata),
        .m_addr    (m_addr),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester byte queues: {last, data}. Popped on the matching req_ready.
    logic [8:0]  rq [N][$];
    logic        st_q[$];        // status bits returned by successive reads
    logic [35:0] exp_tx[$];      // {wstrb, wdata} of each expected bus transaction
    int          exp_ack[$];     // expected req_ready index order

    bit hold_low  = 1'b0;
    bit stuck     = 1'b0;
    bit prev_done = 1'b0;
    int wait_cyc  = 1;
    int scnt      = 0;
    int lat_start = 0;
    int lat_idx   = -1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd();
        exp_tx.push_back({4'b0000, 32'h0});
    endtask

    task automatic push_wr(input logic [7:0] b, input int idx);
        exp_tx.push_back({4'b0001, 24'h0, b});
        exp_ack.push_back(idx);
    endtask

    function automatic bit pending();
        bit p;
        p = busy || (exp_tx.size() != 0) || (exp_ack.size() != 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (pending() && t < IDLE_BUDGET) begin
            tick();
            t++;
        end
        n_cmp++;
        if (t >= IDLE_BUDGET) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d tx and %0d acks outstanding, required 0",
                     name, exp_tx.size(), exp_ack.size());
            exp_tx.delete();
            exp_ack.delete();
            for (int i = 0; i < N; i++) rq[i].delete();
        end
        tick();
        tick();
    endtask

    // Monitor, scoreboard, slave model and requester drivers, all evaluated
    // on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (reset) begin
            scnt      = 0;
            m_ready   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("gap_before_tx", m_valid, 1'b0);
            prev_done = 1'b0;

            if (req_ready != '0) begin
                if (exp_ack.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_unexpected: got req_ready=%b, required none", req_ready);
                end else begin
                    int idx;
                    idx = exp_ack.pop_front();
                    check("ack_index", req_ready, 36'(1 << idx));
                    check("grant_id", grant_id, idx);
                end
                for (int i = 0; i < N; i++)
                    if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                if (lat_idx >= 0 && req_ready[lat_idx]) begin
                    check("latency", cyc - lat_start, 6);
                    lat_idx = -1;
                end
            end

            if (!m_valid) begin
                scnt    = 0;
                m_ready = stuck;
            end else begin
                scnt++;
                m_ready = stuck || (!hold_low && scnt > wait_cyc);
            end
            if (m_valid && m_ready) begin
                if (m_wstrb == 4'b0000)
                    m_rdata = {31'b0, (st_q.size() != 0) ? st_q.pop_front() : 1'b1};
                check("m_addr", m_addr, ADDR);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got wstrb=%b wdata=%0h, required none", m_wstrb, m_wdata);
                end else begin
                    check("tx", {m_wstrb, m_wdata}, exp_tx.pop_front());
                end
                prev_done = 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                logic [8:0] f;
                f = (rq[i].size() != 0) ? rq[i][0] : 9'h0;
                req_valid[i]         = (rq[i].size() != 0);
                req_data[8*i +: 8]   = f[7:0];
                req_last[i]          = f[8];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach summary, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        repeat (3) tick();

        check("rst_m_valid",   m_valid,   1'b0);
        check("rst_m_wstrb",   m_wstrb,   4'h0);
        check("rst_m_wdata",   m_wdata,   32'h0);
        check("rst_m_addr",    m_addr,    32'h0);
        check("rst_req_ready", req_ready, 4'h0);
        check("rst_grant_id",  grant_id,  2'd0);
        check("rst_busy",      busy,      1'b0);
        check("rst_m_instr",   m_instr,   1'b0);
        reset = 1'b0;
        tick();

        // Single request on index 2, UART empty: RD, GAP, WR and a 6-cycle ack.
        st_q.push_back(1'b1);
        push_rd();
        push_wr(8'h41, 2);
        rq[2].push_back({1'b1, 8'h41});
        lat_start = cyc;
        lat_idx   = 2;
        wait_idle("single_req");
        check("latency_seen", (lat_idx == -1), 1'b1);

        // Status reads 0,0,0,1: four polls then one write (requester 3).
        st_q.push_back(1'b0);
        st_q.push_back(1'b0);
        st_q.push_back(1'b0);
        st_q.push_back(1'b1);
        repeat (4) push_rd();
        push_wr(8'h5A, 3);
        rq[3].push_back({1'b1, 8'h5A});
        wait_idle("repoll");

        // All four requesters continuously valid, two bytes each, slower slave.
        wait_cyc = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                logic [7:0] b;
                b = 8'(8'h10 * (r + 1) + i);
                rq[i].push_back({1'b1, b});
                push_rd();
                push_wr(b, i);
            end
        end
        wait_idle("round_robin");
        wait_cyc = 1;

        // Requester 1 sends a 3-byte message while 0 and 3 join after its grant.
        rq[1].push_back({1'b0, 8'hA1});
        rq[1].push_back({1'b0, 8'hA2});
        rq[1].push_back({1'b1, 8'hA3});
`ifdef UART_ARB_LOCK_EN
        push_rd(); push_wr(8'hA1, 1);
        push_rd(); push_wr(8'hA2, 1);
        push_rd(); push_wr(8'hA3, 1);
        push_rd(); push_wr(8'hC3, 3);
        push_rd(); push_wr(8'hB0, 0);
`else
        push_rd(); push_wr(8'hA1, 1);
        push_rd(); push_wr(8'hC3, 3);
        push_rd(); push_wr(8'hB0, 0);
        push_rd(); push_wr(8'hA2, 1);
        push_rd(); push_wr(8'hA3, 1);
`endif
        begin
            int t;
            t = 0;
            while (!busy && t < 50) begin
                tick();
                t++;
            end
            check("msg_granted", busy, 1'b1);
        end
        rq[0].push_back({1'b1, 8'hB0});
        rq[3].push_back({1'b1, 8'hC3});
        wait_idle("message");

        // Reset during WR with m_ready held low; grant restarts at index 0.
        push_rd();
        rq[2].push_back({1'b1, 8'h55});
        begin
            int t;
            t = 0;
            while (!(m_valid && m_wstrb == 4'b0001) && t < 200) begin
                tick();
                t++;
            end
            check("reached_wr", m_valid && (m_wstrb == 4'b0001), 1'b1);
        end
        hold_low = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_m_valid",   m_valid,   1'b0);
        check("abort_busy",      busy,      1'b0);
        check("abort_req_ready", req_ready, 4'h0);
        exp_tx.delete();
        exp_ack.delete();
        st_q.delete();
        rq[0].push_back({1'b1, 8'h50});
        rq[3].push_back({1'b1, 8'h53});
        push_rd(); push_wr(8'h50, 0);
        push_rd(); push_wr(8'h55, 2);
        push_rd(); push_wr(8'h53, 3);
        tick();
        hold_low = 1'b0;
        reset    = 1'b0;
        wait_idle("after_reset");

        // m_ready stuck high: no completion outside RD/WR, gaps still present.
        stuck = 1'b1;
        st_q.push_back(1'b0);
        st_q.push_back(1'b1);
        push_rd();
        push_rd();
        push_wr(8'h77, 1);
        rq[1].push_back({1'b1, 8'h77});
        wait_idle("stuck_ready");
        stuck = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, range 2..8: number of byte requesters.
REQ-002 The block SHALL have parameter UART_ADDR, default 32'hFFFF_0040: bus address of the UART transmitter.
REQ-003 The block SHALL have port clk  input  1  single clock for all logic.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 The block SHALL have port req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
REQ-007 The block SHALL have port req_last  input  NUM_REQ  byte closes a message; used only when the message lock is compiled in.
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  one-cycle pulse: the byte has been handed to the UART.
REQ-009 The block SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-010 The block SHALL have port busy  output  1  high whenever the state is not ARB.
REQ-011 The block SHALL have bus-master ports m_valid (output, 1), m_instr (output, 1, tied 0), m_wstrb (output, 4), m_wdata (output, 32), m_addr (output, 32), m_ready (input, 1) and m_rdata (input, 32).

Function
REQ-012 The FSM SHALL have states ARB, RD, WR and GAP, with a 1-bit next-target register selecting RD, WR or ARB after GAP.
REQ-013 In ARB, if any eligible req_valid is high, the block SHALL register the round-robin winner into grant_id and go to RD; otherwise it SHALL stay in ARB.
REQ-014 Round-robin search SHALL start at (last grant + 1) mod NUM_REQ; after reset, index 0 SHALL be searched first.
REQ-015 In RD the block SHALL drive m_valid=1, m_wstrb=4'b0000 and m_addr=UART_ADDR, holding them until m_ready=1.
REQ-016 When RD completes, the block SHALL go to GAP, targeting WR if m_rdata[0]=1 (UART buffer empty) and targeting RD (re-poll) if m_rdata[0]=0.
REQ-017 In WR the block SHALL drive m_valid=1, m_wstrb=4'b0001, m_addr=UART_ADDR and m_wdata={24'b0, granted byte}, holding them until m_ready=1.
REQ-018 When WR completes, the block SHALL go to GAP targeting ARB, and SHALL pulse req_ready[grant_id] for exactly that GAP cycle.
REQ-019 GAP SHALL last exactly one cycle with m_valid=0, so that the slave's registered ready deasserts before the next transaction.
REQ-020 m_ready SHALL be ignored whenever m_valid=0.
REQ-021 A requester SHALL hold req_valid, req_data and req_last stable from assertion until its req_ready pulse; the block SHALL sample req_data only in WR.
REQ-022 With a 1-cycle-ready slave and the UART empty, the latency from req_valid high in ARB to the req_ready pulse SHALL be 6 cycles.
REQ-023 Simultaneous requests SHALL be served one byte per WR, in round-robin order, and no byte SHALL be written twice or dropped.
REQ-024 If the granted requester drops req_valid before its write completes, which is a protocol violation, the block SHALL complete the transaction anyway using the sampled data.

Reset
REQ-025 While reset=1, the block SHALL drive state=ARB, m_valid=0, m_wstrb=0, m_wdata=0, m_addr=0, req_ready=0, grant_id=0, busy=0, round-robin pointer=0 and lock=0.
REQ-026 A reset asserted mid-transaction SHALL abort the transaction immediately; the in-flight byte is undefined and the requester SHALL re-present it.

Configuration
REQ-027 With UART_ARB_LOCK_EN defined, a grant SHALL stay locked to one requester across successive ARB visits until a byte with req_last=1 is accepted, and only that requester SHALL be eligible while locked, indefinitely.
REQ-028 Without UART_ARB_LOCK_EN, req_last SHALL be ignored, the block SHALL re-arbitrate after every byte, and no lock register SHALL exist.

Structure
REQ-029 Package uart_arb_pkg SHALL hold the state enum, STATUS_EMPTY_BIT=0, WSTRB_READ=4'b0000 and WSTRB_BYTE0=4'b0001.
REQ-030 The round-robin pick SHALL be sub-module uart_rr_pick: combinational, taking the request vector and pointer and returning the winner index and a found flag.

Verification
REQ-031 The bench SHALL check: single request on index 2 with data 8'h41 and status=1 -> RD, GAP, WR with m_wdata=32'h41, and req_ready[2] 6 cycles after req_valid.
REQ-032 The bench SHALL check: status read returning 0 three times, then 1 -> four RD transactions separated by GAP, then exactly one WR.
REQ-033 The bench SHALL check: all 4 requesters valid continuously -> grant order 0,1,2,3,0 and each requester acked once per round.
REQ-034 The bench SHALL check, with UART_ARB_LOCK_EN: requester 1 sends 3 bytes (last on the third) while 0 and 3 request -> bytes from 1 are contiguous, then 3, then 0.
REQ-035 The bench SHALL check: reset asserted during WR with m_ready held low -> m_valid=0 at once, and after release the first grant goes to index 0.
REQ-036 The bench SHALL check: m_ready stuck at 1 during GAP/ARB -> no spurious completion, and every transaction shows m_valid low for at least one cycle before it starts.
